// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO, run-time frame format (5..DATABITS data, parity, 1/2 stop).
// Optional break generation is compiled in with `define UART_TX_BREAK_EN (adds input send_break).
module uart_tx_fifo #(
    parameter int DATABITS   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          baud_tick,
    input  logic [DATABITS-1:0]           s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [3:0]                    data_len,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                          send_break,
`endif
    output logic                          tx_line,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [2:0]                    fsm_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [3:0]  MAXLEN = 4'(DATABITS);

    // Handshake: a word moves on every clk edge where s_valid && s_ready; the host
    // must hold s_data stable while s_valid is high and s_ready is low.

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic [DATABITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           level_nxt;
    logic                  push, pop, brk_req, brk_on, stop_end;
    logic [3:0]            len_eff, f_len, bit_cnt;
    logic [DATABITS-1:0]   head_masked, shreg;
    logic                  f_par_en, f_par_bit, f_stop2, stop_cnt;

`ifdef UART_TX_BREAK_EN
    assign brk_req = send_break;
`else
    assign brk_req = 1'b0;
`endif

    assign fsm_state = state;
    assign push      = s_valid && s_ready;
    assign stop_end  = (state == STOP) && (stop_cnt == f_stop2);
    // A pop starts a frame: from IDLE, or chained straight off the final stop tick.
    assign pop = baud_tick && (fifo_level != '0) && !brk_req &&
                 (((state == IDLE) && !brk_on) || stop_end);

    always_comb begin
        len_eff = data_len;
        if (data_len < 4'd5)
            len_eff = 4'd5;
        else if (data_len > MAXLEN)
            len_eff = MAXLEN;
    end

    // Bits above the frame length are zeroed so the parity covers only sent bits.
    always_comb begin
        head_masked = '0;
        for (int i = 0; i < DATABITS; i++)
            if (4'(i) < len_eff)
                head_masked[i] = mem[rd_ptr][i];
    end

    always_comb begin
        level_nxt = fifo_level;
        if (push && !pop)
            level_nxt = fifo_level + 1'b1;
        else if (pop && !push)
            level_nxt = fifo_level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            s_ready    <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= level_nxt;
            s_ready    <= (level_nxt != FULL);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tx_line   <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            f_len     <= 4'd5;
            f_par_en  <= 1'b0;
            f_par_bit <= 1'b0;
            f_stop2   <= 1'b0;
            stop_cnt  <= 1'b0;
            brk_on    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (baud_tick) begin
                case (state)
                    IDLE: begin
                        if (brk_on) begin
                            if (!brk_req) begin
                                brk_on  <= 1'b0;
                                tx_line <= 1'b1;
                            end
                        end else if (brk_req) begin
                            brk_on  <= 1'b1;
                            tx_line <= 1'b0;
                        end
                    end
                    START: begin
                        tx_line <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= 4'd1;
                        state   <= DATA;
                    end
                    DATA: begin
                        if (bit_cnt == f_len) begin
                            if (f_par_en) begin
                                tx_line <= f_par_bit;
                                state   <= PARITY;
                            end else begin
                                tx_line  <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            tx_line <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    PARITY: begin
                        tx_line  <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                    STOP: begin
                        if (!stop_end) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            tx_done <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            // Frame start overrides the IDLE/STOP outcome above when a word is popped.
            if (pop) begin
                shreg     <= head_masked;
                f_len     <= len_eff;
                f_par_en  <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
                f_par_bit <= (^head_masked) ^ (parity_mode == 2'd2);
                f_stop2   <= stop2;
                tx_line   <= 1'b0;
                busy      <= 1'b1;
                state     <= START;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: a frame-level model predicts tx_line, busy, tx_done,
// fifo_level and s_ready every clock; directed frames are also checked against fixed bit patterns.
module tb_uart_tx_fifo;
    localparam int DB    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          baud_tick = 1'b0;
    logic [DB-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [3:0]    data_len = 4'd8;
    logic [1:0]    parity_mode = 2'd0;
    logic          stop2 = 1'b0;
    logic          tx_line, busy, tx_done;
    logic [2:0]    fifo_level;
    logic [2:0]    fsm_state;
`ifdef UART_TX_BREAK_EN
    logic          send_break = 1'b0;
`endif

    uart_tx_fifo #(.DATABITS(DB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .data_len(data_len), .parity_mode(parity_mode), .stop2(stop2),
`ifdef UART_TX_BREAK_EN
        .send_break(send_break),
`endif
        .tx_line(tx_line), .busy(busy), .tx_done(tx_done),
        .fifo_level(fifo_level), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DB-1:0] word_q[$];
    logic          bits[$];
    logic          in_frame = 1'b0;
    logic          brk_on = 1'b0;
    logic          e_line = 1'b1, e_busy = 1'b0, e_done = 1'b0;
    logic          tk, pv, sb, pushed;
    logic [DB-1:0] pd;
    logic [3:0]    cdl;
    logic [1:0]    cpm;
    logic          cs2;
    int            tick_cnt = 0;
    int            done_cnt = 0;
    int            done_idx = -1;
    logic          tick_log[$];

    function automatic void build_frame(input logic [DB-1:0] w, input logic [3:0] dl,
                                        input logic [1:0] pm, input logic s2);
        int  n;
        logic p;
        n = (dl < 5) ? 5 : ((dl > DB) ? DB : int'(dl));
        p = 1'b0;
        bits.delete();
        for (int i = 0; i < n; i++) begin
            bits.push_back(w[i]);
            p ^= w[i];
        end
        if (pm == 2'd1) bits.push_back(p);
        else if (pm == 2'd2) bits.push_back(~p);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
    endfunction

    always @(posedge clk) begin
        tk = baud_tick; pv = s_valid; pd = s_data;
        cdl = data_len; cpm = parity_mode; cs2 = stop2;
`ifdef UART_TX_BREAK_EN
        sb = send_break;
`else
        sb = 1'b0;
`endif
        if (!reset_n) begin
            word_q.delete(); bits.delete();
            in_frame = 1'b0; brk_on = 1'b0;
            e_line = 1'b1; e_done = 1'b0;
        end else begin
            e_done = 1'b0;
            pushed = pv && (word_q.size() < DEPTH);
            if (tk) begin
                tick_cnt++;
                if (bits.size() != 0) begin
                    e_line = bits.pop_front();
                end else begin
                    if (in_frame) begin
                        e_done   = 1'b1;
                        in_frame = 1'b0;
                    end
                    if (brk_on) begin
                        if (!sb) begin
                            brk_on = 1'b0;
                            e_line = 1'b1;
                        end
                    end else if (sb) begin
                        if (e_done) e_line = 1'b1;
                        else begin
                            brk_on = 1'b1;
                            e_line = 1'b0;
                        end
                    end else if (word_q.size() != 0) begin
                        build_frame(word_q.pop_front(), cdl, cpm, cs2);
                        e_line   = 1'b0;
                        in_frame = 1'b1;
                    end else begin
                        e_line = 1'b1;
                    end
                end
            end
            if (pushed) word_q.push_back(pd);
        end
        e_busy = in_frame;
        #1;
        check("tx_line", 32'(tx_line), 32'(e_line));
        check("busy", 32'(busy), 32'(e_busy));
        check("tx_done", 32'(tx_done), 32'(e_done));
        check("fifo_level", 32'(fifo_level), 32'(word_q.size()));
        check("s_ready", 32'(s_ready), 32'(word_q.size() < DEPTH));
        if (tk && reset_n) tick_log.push_back(tx_line);
        if (tx_done) begin
            done_cnt++;
            done_idx = tick_log.size() - 1;
        end
    end

    // ---------------- drivers ----------------
    int tick_mode = 0;  // 0 off, 1 random, 2 every clk, 3 manual
    always @(negedge clk) begin
        if (tick_mode == 1) baud_tick = ($urandom_range(0, 2) == 0);
        else if (tick_mode == 2) baud_tick = 1'b1;
        else if (tick_mode == 0) baud_tick = 1'b0;
    end

    task automatic push_word(input logic [DB-1:0] w);
        logic was_ready;
        s_data = w;
        s_valid = 1'b1;
        for (int n = 0; n < 5000; n++) begin
            was_ready = s_ready;
            @(negedge clk);
            if (was_ready) begin
                s_valid = 1'b0;
                s_data = DB'($urandom);
                return;
            end
        end
        s_valid = 1'b0;
        check("push_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (word_q.size() == 0 && !in_frame && bits.size() == 0) return;
        end
        check("idle_timeout", 0, 1);
    endtask

    task automatic send_frame(input logic [DB-1:0] w);
        tick_mode = 3;
        baud_tick = 1'b0;
        push_word(w);
        tick_log.delete();
        done_idx = -1;
        tick_mode = 1;
        wait_idle();
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [15:0] log_bits(input int n);
        logic [15:0] v = '0;
        for (int i = 0; i < n && i < tick_log.size(); i++) v = {v[14:0], tick_log[i]};
        return v;
    endfunction

    task automatic reset_now();
        #2 reset_n = 1'b0;
        #1;
        check("rst_tx_line", 32'(tx_line), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_ready", 32'(s_ready), 1);
        check("rst_done", 32'(tx_done), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        reset_now();
        repeat (2) @(negedge clk);

        // 8N1 0xA5
        d0 = done_cnt;
        send_frame(8'hA5);
        check("a5_bits", 32'(log_bits(10)), 32'(10'b0101001011));
        check("a5_done_cnt", 32'(done_cnt - d0), 1);
        check("a5_done_at", 32'(done_idx), 10);

        // even / odd parity with two stop bits: 5A has four ones
        data_len = 4'd8; parity_mode = 2'd1; stop2 = 1'b1;
        send_frame(8'h5A);
        check("even_bits", 32'(log_bits(12)), 32'(12'b001011010011));
        parity_mode = 2'd2;
        send_frame(8'h5A);
        check("odd_bits", 32'(log_bits(12)), 32'(12'b001011010111));
        check("odd_done_at", 32'(done_idx), 12);

        // five data bits
        data_len = 4'd5; parity_mode = 2'd0; stop2 = 1'b0;
        send_frame(8'h1F);
        check("len5_bits", 32'(log_bits(7)), 32'(7'b0111111));
        check("len5_done_at", 32'(done_idx), 7);

        // clamping of out-of-range lengths
        data_len = 4'd2; send_frame(8'hE3);
        check("len2_done_at", 32'(done_idx), 7);
        data_len = 4'd15; send_frame(8'hE3);
        check("len15_done_at", 32'(done_idx), 10);

        // fill the FIFO with ticks held low
        data_len = 4'd8;
        tick_mode = 3; baud_tick = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_word(DB'(8'h10 + i));
        check("full_level", 32'(fifo_level), DEPTH);
        check("full_ready", 32'(s_ready), 0);
        s_data = 8'h77; s_valid = 1'b1;
        @(negedge clk);
        check("full_hold_level", 32'(fifo_level), DEPTH);
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
        check("pop_level", 32'(fifo_level), DEPTH - 1);
        check("pop_ready", 32'(s_ready), 1);
        push_word(8'h77);
        tick_mode = 1;
        wait_idle();

        // reset during the third data bit with words still queued
        tick_mode = 3; baud_tick = 1'b0;
        for (int i = 0; i < 3; i++) push_word(DB'($urandom));
        tick_mode = 2;
        for (int n = 0; n < 200 && !(in_frame && bits.size() == 6); n++) @(negedge clk);
        check("reached_data2", 32'(in_frame && bits.size() == 6), 1);
        reset_now();
        tick_mode = 1;
        repeat (40) @(negedge clk);

        // randomized traffic with config changes
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                data_len = 4'($urandom_range(0, 15));
                parity_mode = 2'($urandom);
                stop2 = 1'($urandom);
            end
            if (k == 20) tick_mode = 2;
            if (k == 30) tick_mode = 1;
            push_word(DB'($urandom));
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        wait_idle();

`ifdef UART_TX_BREAK_EN
        // break for 20 ticks with a word queued
        data_len = 4'd8; parity_mode = 2'd0; stop2 = 1'b0;
        tick_mode = 3; baud_tick = 1'b0;
        send_break = 1'b1;
        push_word(8'h3C);
        tick_log.delete();
        tick_mode = 1;
        for (int n = 0; n < 2000 && tick_log.size() < 20; n++) @(negedge clk);
        send_break = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        check("brk_low", 32'(log_bits(20)), 32'(20'h0));
        check("brk_gap_then_start", 32'(log_bits(22) & 16'h3), 32'(2'b10));
`endif

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
